pulse_monitor: RTL and testbench

Receiving end of the pulse `controller`'s output. It samples the `pulse` line in the `clk` domain and measures each pulse's high width and the rising-edge-to-rising-edge period. It counts pulses, decides whether the stream is repeating at a fixed period (the controller's `per` mode) or is isolated single pulses, and times out when the stream stops. It feeds the verification status logic and the on-board status LEDs.

---
 rtl/pulse_monitor.sv | 177 +++++++++++++++++
 tb/tb_pulse_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_monitor.sv
// Purpose: measures width/period of a same-domain pulse stream, counts pulses, flags periodicity and train timeout.
// Latency: every output is registered; strobes and counters appear one cycle after the sampled pulse edge.
// Backpressure: none; the monitor samples every cycle and never stalls the pulse source.
//
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   pulse        - sampled pulse stream
//   clr          - synchronous clear of statistics (FSM and running counters keep going)
//   busy         - FSM not in IDLE
//   pulse_cnt    - rising-edge count, wraps
//   last_width   - high width of the most recent completed pulse, width_vld strobes on update
//   last_period  - rise-to-rise distance of the last two pulses, period_vld strobes on update
//   periodic     - last two measured periods equal
//   timeout      - one-cycle strobe when a train ends through a long low gap
module pulse_monitor #(
  parameter int CW      = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pulse,
  input  logic          clr,
  output logic          busy,
  output logic [7:0]    pulse_cnt,
  output logic [CW-1:0] last_width,
  output logic          width_vld,
  output logic [CW-1:0] last_period,
  output logic          period_vld,
  output logic          periodic,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [CW-1:0] width_cnt_q, width_cnt_d;
  logic [CW-1:0] period_cnt_q, period_cnt_d;
  logic          have_period_q, have_period_d;
  logic          busy_q, busy_d;
  logic [7:0]    pulse_cnt_q, pulse_cnt_d;
  logic [CW-1:0] last_width_q, last_width_d;
  logic          width_vld_q, width_vld_d;
  logic [CW-1:0] last_period_q, last_period_d;
  logic          period_vld_q, period_vld_d;
  logic          periodic_q, periodic_d;
  logic          timeout_q, timeout_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    state_d       = state_q;
    width_cnt_d   = width_cnt_q;
    period_cnt_d  = period_cnt_q;
    have_period_d = have_period_q;
    pulse_cnt_d   = pulse_cnt_q;
    last_width_d  = last_width_q;
    width_vld_d   = 1'b0;
    last_period_d = last_period_q;
    period_vld_d  = 1'b0;
    periodic_d    = periodic_q;
    timeout_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // First rise of a train: no previous rise, so no period exists yet.
        if (pulse) begin
          state_d      = HIGH;
          width_cnt_d  = CNT_ONE;
          period_cnt_d = CNT_ONE;
          pulse_cnt_d  = pulse_cnt_q + 8'd1;
        end
      end
      HIGH: begin
        if (pulse) begin
          width_cnt_d  = sat_inc(width_cnt_q);
          period_cnt_d = sat_inc(period_cnt_q);
        end else begin
          last_width_d = width_cnt_q;
          width_vld_d  = 1'b1;
          period_cnt_d = sat_inc(period_cnt_q);
          state_d      = LOW;
        end
      end
      LOW: begin
        // A rise takes priority over a timeout landing in the same cycle.
        if (pulse) begin
          last_period_d = period_cnt_q;
          period_vld_d  = 1'b1;
          if (have_period_q) begin
            periodic_d = (period_cnt_q == last_period_q);
          end else begin
            periodic_d    = 1'b0;
            have_period_d = 1'b1;
          end
          period_cnt_d = CNT_ONE;
          width_cnt_d  = CNT_ONE;
          pulse_cnt_d  = pulse_cnt_q + 8'd1;
          state_d      = HIGH;
        end else if (period_cnt_q >= TO_VAL) begin
          // >= so a pulse held high longer than TIMEOUT still ends the
          // train on its first low check instead of counting forever.
          state_d       = IDLE;
          timeout_d     = 1'b1;
          periodic_d    = 1'b0;
          have_period_d = 1'b0;
        end else begin
          period_cnt_d = sat_inc(period_cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wipes statistics only; the running measurement continues so a
    // pulse in flight is still timed. A rise in the clear cycle goes uncounted.
    if (clr) begin
      pulse_cnt_d   = 8'd0;
      last_width_d  = '0;
      last_period_d = '0;
      periodic_d    = 1'b0;
      have_period_d = 1'b0;
      width_vld_d   = 1'b0;
      period_vld_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      width_cnt_q   <= '0;
      period_cnt_q  <= '0;
      have_period_q <= 1'b0;
      busy_q        <= 1'b0;
      pulse_cnt_q   <= 8'd0;
      last_width_q  <= '0;
      width_vld_q   <= 1'b0;
      last_period_q <= '0;
      period_vld_q  <= 1'b0;
      periodic_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      width_cnt_q   <= width_cnt_d;
      period_cnt_q  <= period_cnt_d;
      have_period_q <= have_period_d;
      busy_q        <= busy_d;
      pulse_cnt_q   <= pulse_cnt_d;
      last_width_q  <= last_width_d;
      width_vld_q   <= width_vld_d;
      last_period_q <= last_period_d;
      period_vld_q  <= period_vld_d;
      periodic_q    <= periodic_d;
      timeout_q     <= timeout_d;
    end
  end

  assign busy        = busy_q;
  assign pulse_cnt   = pulse_cnt_q;
  assign last_width  = last_width_q;
  assign width_vld   = width_vld_q;
  assign last_period = last_period_q;
  assign period_vld  = period_vld_q;
  assign periodic    = periodic_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// Directed bench for pulse_monitor with TIMEOUT=20.
module tb_pulse_monitor;
  localparam int CW = 16;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pulse;
  logic          clr;
  logic          busy;
  logic [7:0]    pulse_cnt;
  logic [CW-1:0] last_width;
  logic          width_vld;
  logic [CW-1:0] last_period;
  logic          period_vld;
  logic          periodic;
  logic          timeout;

  int checks = 0;
  int passes = 0;
  int wv_cnt = 0;
  int pv_cnt = 0;
  int to_cnt = 0;

  pulse_monitor #(.CW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .clr(clr),
    .busy(busy), .pulse_cnt(pulse_cnt),
    .last_width(last_width), .width_vld(width_vld),
    .last_period(last_period), .period_vld(period_vld),
    .periodic(periodic), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Drive one sample, clock it, observe the registered result 1ns later.
  task automatic step(input logic p);
    pulse = p;
    @(posedge clk);
    #1;
    if (width_vld)  wv_cnt++;
    if (period_vld) pv_cnt++;
    if (timeout)    to_cnt++;
  endtask

  task automatic zero_strobes();
    wv_cnt = 0; pv_cnt = 0; to_cnt = 0;
  endtask

  // Hold pulse low until the monitor returns to IDLE, bounded.
  task automatic drain(output int n);
    n = 0;
    while (busy && n < 40) begin
      step(1'b0);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pulse = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, pulse_cnt, last_width, width_vld, last_period, period_vld, periodic, timeout} !== '0)
      $display("FAIL reset_outputs: busy=%b cnt=%0d lw=%0d wv=%b lp=%0d pv=%b per=%b to=%b required all 0",
               busy, pulse_cnt, last_width, width_vld, last_period, period_vld, periodic, timeout);
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_pulse();
    int n;
    zero_strobes();
    step(1'b1);
    checks++; if (busy !== 1'b1) $display("FAIL single_busy: busy=%b required 1", busy); else passes++;
    checks++; if (pulse_cnt !== 8'd1) $display("FAIL single_cnt: pulse_cnt=%0d required 1", pulse_cnt); else passes++;
    step(1'b0);
    checks++; if (width_vld !== 1'b1) $display("FAIL single_wvld: width_vld=%b required 1", width_vld); else passes++;
    checks++; if (last_width !== 16'd1) $display("FAIL single_width: last_width=%0d required 1", last_width); else passes++;
    for (int s = 2; s < TO; s++) step(1'b0);
    checks++; if (to_cnt !== 0) $display("FAIL single_early_to: timeouts=%0d required 0", to_cnt); else passes++;
    step(1'b0);
    checks++; if (timeout !== 1'b1) $display("FAIL single_timeout: timeout=%b required 1", timeout); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL single_idle: busy=%b required 0", busy); else passes++;
    checks++; if (pv_cnt !== 0) $display("FAIL single_no_pvld: period_vld count=%0d required 0", pv_cnt); else passes++;
    checks++; if (wv_cnt !== 1) $display("FAIL single_wvld_once: width_vld count=%0d required 1", wv_cnt); else passes++;
    checks++; if (periodic !== 1'b0) $display("FAIL single_periodic: periodic=%b required 0", periodic); else passes++;
    n = 0;
  endtask

  task automatic test_periodic();
    logic exp_per;
    clr = 1'b1;
    step(1'b0);
    clr = 1'b0;
    checks++; if (pulse_cnt !== 8'd0 || last_width !== 16'd0)
      $display("FAIL clr_idle: pulse_cnt=%0d last_width=%0d required 0 0", pulse_cnt, last_width); else passes++;
    zero_strobes();
    for (int k = 1; k <= 6; k++) begin
      step(1'b1);
      exp_per = (k >= 3);
      checks++; if (periodic !== exp_per)
        $display("FAIL train_periodic_%0d: periodic=%b required %b", k, periodic, exp_per); else passes++;
      repeat (4) step(1'b0);
    end
    checks++; if (pv_cnt !== 5) $display("FAIL train_pvld: period_vld count=%0d required 5", pv_cnt); else passes++;
    checks++; if (last_period !== 16'd5) $display("FAIL train_period: last_period=%0d required 5", last_period); else passes++;
    checks++; if (pulse_cnt !== 8'd6) $display("FAIL train_cnt: pulse_cnt=%0d required 6", pulse_cnt); else passes++;
  endtask

  task automatic test_period_change();
    int n;
    step(1'b1);
    checks++; if (periodic !== 1'b1) $display("FAIL chg_before: periodic=%b required 1", periodic); else passes++;
    repeat (6) step(1'b0);
    step(1'b1);
    checks++; if (period_vld !== 1'b1) $display("FAIL chg_pvld: period_vld=%b required 1", period_vld); else passes++;
    checks++; if (last_period !== 16'd7) $display("FAIL chg_period: last_period=%0d required 7", last_period); else passes++;
    checks++; if (periodic !== 1'b0) $display("FAIL chg_periodic: periodic=%b required 0", periodic); else passes++;
    drain(n);
    checks++; if (busy !== 1'b0) $display("FAIL chg_drain: busy=%b after %0d cycles required 0", busy, n); else passes++;
  endtask

  task automatic test_timeout_race();
    int n;
    zero_strobes();
    step(1'b1);
    for (int s = 1; s < TO; s++) step(1'b0);
    step(1'b1);
    checks++; if (timeout !== 1'b0 || to_cnt !== 0)
      $display("FAIL race_timeout: timeout=%b count=%0d required 0 0", timeout, to_cnt); else passes++;
    checks++; if (period_vld !== 1'b1) $display("FAIL race_pvld: period_vld=%b required 1", period_vld); else passes++;
    checks++; if (last_period !== 16'(TO)) $display("FAIL race_period: last_period=%0d required %0d", last_period, TO); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL race_busy: busy=%b required 1", busy); else passes++;
    drain(n);
    checks++; if (busy !== 1'b0) $display("FAIL race_drain: busy=%b after %0d cycles required 0", busy, n); else passes++;
  endtask

  task automatic test_async_reset();
    int n;
    step(1'b1);
    step(1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, pulse_cnt, last_width, width_vld, last_period, period_vld, periodic, timeout} !== '0)
      $display("FAIL arst_outputs: busy=%b cnt=%0d lw=%0d lp=%0d required all 0", busy, pulse_cnt, last_width, last_period);
    else passes++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1);
    checks++; if (pulse_cnt !== 8'd1 || busy !== 1'b1)
      $display("FAIL arst_recount: pulse_cnt=%0d busy=%b required 1 1", pulse_cnt, busy); else passes++;
    checks++; if (period_vld !== 1'b0) $display("FAIL arst_pvld: period_vld=%b required 0", period_vld); else passes++;
    step(1'b0);
    checks++; if (last_width !== 16'd1) $display("FAIL arst_width: last_width=%0d required 1", last_width); else passes++;
    drain(n);
    checks++; if (busy !== 1'b0) $display("FAIL arst_drain: busy=%b after %0d cycles required 0", busy, n); else passes++;
  endtask

  task automatic test_clr_rise();
    for (int k = 0; k < 3; k++) begin
      repeat (3) step(1'b1);
      repeat (2) step(1'b0);
    end
    checks++; if (periodic !== 1'b1 || last_width !== 16'd3)
      $display("FAIL clr_pre: periodic=%b last_width=%0d required 1 3", periodic, last_width); else passes++;
    clr = 1'b1;
    step(1'b1);
    clr = 1'b0;
    checks++; if (pulse_cnt !== 8'd0 || periodic !== 1'b0)
      $display("FAIL clr_rise: pulse_cnt=%0d periodic=%b required 0 0", pulse_cnt, periodic); else passes++;
    checks++; if (period_vld !== 1'b0) $display("FAIL clr_pvld: period_vld=%b required 0", period_vld); else passes++;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    checks++; if (last_width !== 16'd3) $display("FAIL clr_width: last_width=%0d required 3", last_width); else passes++;
    step(1'b0);
    step(1'b1);
    checks++; if (pulse_cnt !== 8'd1) $display("FAIL clr_next_cnt: pulse_cnt=%0d required 1", pulse_cnt); else passes++;
    checks++; if (period_vld !== 1'b1 || last_period !== 16'd5)
      $display("FAIL clr_next_period: period_vld=%b last_period=%0d required 1 5", period_vld, last_period); else passes++;
    checks++; if (periodic !== 1'b0) $display("FAIL clr_next_periodic: periodic=%b required 0", periodic); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_periodic();
    test_period_change();
    test_timeout_race();
    test_async_reset();
    test_clr_rise();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
